// File: rtl/uart_frame_gen_chk.sv
// uart_frame_gen_chk: built-in self-test source for a UART receiver.
// Serialises one frame per start request (start, DATA_W data bits LSB first,
// optional even-parity or CRC-8 check field, stop, idle gap) and counts the
// rx / error interrupt edges raised by the UART under test.
// Optional per-frame result checking is enabled by defining
// UART_GEN_CHK_AUTOCHK_EN; without it mismatch_o / mismatch_cnt_o stay 0.
module uart_frame_gen_chk #(
   parameter int          DATA_W     = 8,
   parameter logic [7:0]  CRC_POLY   = 8'h07,
   parameter int          BIT_TIME_W = 16,
   parameter int          CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   input  logic                  inject_err_i,
   input  logic [DATA_W-1:0]     data_i,
   input  logic [BIT_TIME_W-1:0] bit_time_i,
   input  logic [3:0]            idle_bits_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  rx_int_i,
   input  logic                  err_int_i,
   input  logic                  cnt_clr_i,
   output logic [CNT_W-1:0]      rx_cnt_o,
   output logic [CNT_W-1:0]      err_cnt_o,
   output logic [CNT_W-1:0]      sent_cnt_o,
   output logic                  mismatch_o,
   output logic [CNT_W-1:0]      mismatch_cnt_o
);

   localparam int IDX_W = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_CHECK,
      S_STOP,
      S_GAP
   } state_t;

   state_t                state_q, state_d;
   logic [BIT_TIME_W-1:0] bit_time_q;
   logic [BIT_TIME_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]     data_sh_q, data_sh_d;
   logic [7:0]            chk_sh_q, chk_sh_d;
   logic [3:0]            chk_len_q;
   logic [3:0]            idle_bits_q;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic                  done_q, done_d;
   logic                  accept;
   logic                  bit_end;
   logic [7:0]            crc_val;
   logic                  crc_fb;
   logic [7:0]            chk_field;
   logic [3:0]            chk_len;
   logic                  rx_q, err_q;
   logic                  rx_edge, err_edge;
   logic [CNT_W-1:0]      rx_cnt_q, err_cnt_q, sent_cnt_q;

   // A start is taken only from IDLE and never in the done cycle itself
   assign accept  = (state_q == S_IDLE) && start_i && !done_q;
   assign bit_end = (bit_cnt_q == '0);

   // Check field for the frame about to be accepted, built from the live inputs
   always_comb begin
      crc_val   = 8'h00;
      crc_fb    = 1'b0;
      chk_field = 8'h00;
      chk_len   = 4'd0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         crc_fb  = crc_val[7] ^ data_i[i];
         crc_val = {crc_val[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);
      end
      case (mode_i)
         2'b01: begin
            chk_field = {7'b0, (^data_i) ^ inject_err_i};
            chk_len   = 4'd1;
         end
         2'b10: begin
            chk_field = crc_val ^ {7'b0, inject_err_i};
            chk_len   = 4'd8;
         end
         default: ;
      endcase
   end

   // Next-state logic: each bit lasts bit_time+1 clocks, counter reloads at boundaries
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      data_sh_d = data_sh_q;
      chk_sh_d  = chk_sh_q;
      bit_idx_d = bit_idx_q;
      done_d    = 1'b0;
      if (state_q != S_IDLE) begin
         bit_cnt_d = bit_end ? bit_time_q : (bit_cnt_q - BIT_TIME_W'(1));
      end
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_START;
               bit_cnt_d = bit_time_i;
               data_sh_d = data_i;
               chk_sh_d  = chk_field;
               bit_idx_d = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               data_sh_d = data_sh_q >> 1;
               if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                  state_d   = (chk_len_q != 4'd0) ? S_CHECK : S_STOP;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         S_CHECK: begin
            if (bit_end) begin
               chk_sh_d = chk_sh_q >> 1;
               if (bit_idx_q == (IDX_W'(chk_len_q) - IDX_W'(1))) begin
                  state_d   = S_STOP;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               bit_idx_d = '0;
               if (idle_bits_q != 4'd0) begin
                  state_d = S_GAP;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (bit_end) begin
               if (bit_idx_q == (IDX_W'(idle_bits_q) - IDX_W'(1))) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state and bit datapath registers; reset aborts any frame at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         data_sh_q <= '0;
         chk_sh_q  <= '0;
         bit_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         data_sh_q <= data_sh_d;
         chk_sh_q  <= chk_sh_d;
         bit_idx_q <= bit_idx_d;
         done_q    <= done_d;
      end
   end

   // Frame configuration is frozen at acceptance so inputs may change mid-frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_time_q  <= '0;
         chk_len_q   <= '0;
         idle_bits_q <= '0;
      end else if (accept) begin
         bit_time_q  <= bit_time_i;
         chk_len_q   <= chk_len;
         idle_bits_q <= idle_bits_i;
      end
   end

   // Line level follows the state; everything outside a frame idles high
   always_comb begin
      tx_o = 1'b1;
      case (state_q)
         S_START: tx_o = 1'b0;
         S_DATA:  tx_o = data_sh_q[0];
         S_CHECK: tx_o = chk_sh_q[0];
         default: ;
      endcase
   end

   // Interrupt inputs are assumed synchronous to clk; one register gives the edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         rx_q  <= rx_int_i;
         err_q <= err_int_i;
      end
   end

   assign rx_edge  = rx_int_i & ~rx_q;
   assign err_edge = err_int_i & ~err_q;

   // Saturating event counters; a clear wins over any increment in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_cnt_q   <= '0;
         err_cnt_q  <= '0;
         sent_cnt_q <= '0;
      end else if (cnt_clr_i) begin
         rx_cnt_q   <= '0;
         err_cnt_q  <= '0;
         sent_cnt_q <= '0;
      end else begin
         if (rx_edge && (rx_cnt_q != '1)) begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
         end
         if (err_edge && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
         if (done_d && (sent_cnt_q != '1)) begin
            sent_cnt_q <= sent_cnt_q + CNT_W'(1);
         end
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = done_q;
   assign rx_cnt_o   = rx_cnt_q;
   assign err_cnt_o  = err_cnt_q;
   assign sent_cnt_o = sent_cnt_q;

`ifdef UART_GEN_CHK_AUTOCHK_EN
   logic [1:0]       mode_q;
   logic             inject_q;
   logic [1:0]       frm_rx_q, frm_err_q;
   logic             rx_none, rx_one, err_none, err_one;
   logic             expect_err;
   logic             mismatch;
   logic [CNT_W-1:0] mm_cnt_q;

   // Per-frame tally of interrupt edges, starting in the acceptance cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q    <= 2'b00;
         inject_q  <= 1'b0;
         frm_rx_q  <= 2'd0;
         frm_err_q <= 2'd0;
      end else if (accept) begin
         mode_q    <= mode_i;
         inject_q  <= inject_err_i;
         frm_rx_q  <= {1'b0, rx_edge};
         frm_err_q <= {1'b0, err_edge};
      end else if (state_q != S_IDLE) begin
         if (rx_edge && (frm_rx_q != 2'd3)) begin
            frm_rx_q <= frm_rx_q + 2'd1;
         end
         if (err_edge && (frm_err_q != 2'd3)) begin
            frm_err_q <= frm_err_q + 2'd1;
         end
      end
   end

   // Judge the frame in its done cycle, folding in an edge arriving that cycle
   always_comb begin
      rx_none    = (frm_rx_q == 2'd0) && !rx_edge;
      rx_one     = ((frm_rx_q == 2'd0) && rx_edge) || ((frm_rx_q == 2'd1) && !rx_edge);
      err_none   = (frm_err_q == 2'd0) && !err_edge;
      err_one    = ((frm_err_q == 2'd0) && err_edge) || ((frm_err_q == 2'd1) && !err_edge);
      expect_err = inject_q && ((mode_q == 2'b01) || (mode_q == 2'b10));
      mismatch   = done_q && (expect_err ? !(err_one && rx_none) : !(rx_one && err_none));
   end

   // Saturating count of frames whose interrupt outcome was wrong
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mm_cnt_q <= '0;
      end else if (cnt_clr_i) begin
         mm_cnt_q <= '0;
      end else if (mismatch && (mm_cnt_q != '1)) begin
         mm_cnt_q <= mm_cnt_q + CNT_W'(1);
      end
   end

   assign mismatch_o     = mismatch;
   assign mismatch_cnt_o = mm_cnt_q;
`else
   assign mismatch_o     = 1'b0;
   assign mismatch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_uart_frame_gen_chk.sv
// tb_uart_frame_gen_chk: directed bench for uart_frame_gen_chk.
// Counters are narrowed to 4 bits so saturation is reachable quickly.
// Builds with or without UART_GEN_CHK_AUTOCHK_EN; expectations follow the macro.
module tb_uart_frame_gen_chk;

`ifdef UART_GEN_CHK_AUTOCHK_EN
   localparam bit AUTOCHK = 1'b1;
`else
   localparam bit AUTOCHK = 1'b0;
`endif

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          start_i;
   logic [1:0]    mode_i;
   logic          inject_err_i;
   logic [7:0]    data_i;
   logic [15:0]   bit_time_i;
   logic [3:0]    idle_bits_i;
   logic          tx_o;
   logic          busy_o;
   logic          done_o;
   logic          rx_int_i;
   logic          err_int_i;
   logic          cnt_clr_i;
   logic [CW-1:0] rx_cnt_o;
   logic [CW-1:0] err_cnt_o;
   logic [CW-1:0] sent_cnt_o;
   logic          mismatch_o;
   logic [CW-1:0] mismatch_cnt_o;

   int   checks = 0;
   int   errors = 0;
   logic tx_log[$];
   int   busy_clocks;
   int   done_pulses;
   int   mm_at_done;
   int   mm_other;
   bit   frame_done;

   uart_frame_gen_chk #(
      .DATA_W     (8),
      .CRC_POLY   (8'h07),
      .BIT_TIME_W (16),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst_n),
      .start_i        (start_i),
      .mode_i         (mode_i),
      .inject_err_i   (inject_err_i),
      .data_i         (data_i),
      .bit_time_i     (bit_time_i),
      .idle_bits_i    (idle_bits_i),
      .tx_o           (tx_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .rx_int_i       (rx_int_i),
      .err_int_i      (err_int_i),
      .cnt_clr_i      (cnt_clr_i),
      .rx_cnt_o       (rx_cnt_o),
      .err_cnt_o      (err_cnt_o),
      .sent_cnt_o     (sent_cnt_o),
      .mismatch_o     (mismatch_o),
      .mismatch_cnt_o (mismatch_cnt_o)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one frame and record the line every clock until done_o (bounded)
   task automatic run_frame(input logic [1:0] mode, input logic [7:0] data, input logic inj,
                            input logic [15:0] bt, input logic [3:0] idle,
                            input int mid_start_at, input int rx_at, input int err_at);
      @(negedge clk);
      mode_i       = mode;
      data_i       = data;
      inject_err_i = inj;
      bit_time_i   = bt;
      idle_bits_i  = idle;
      start_i      = 1'b1;
      @(negedge clk);
      start_i      = 1'b0;
      data_i       = ~data;
      mode_i       = 2'b11;
      inject_err_i = ~inj;
      bit_time_i   = 16'd0;
      idle_bits_i  = 4'd7;
      tx_log.delete();
      busy_clocks = 0;
      done_pulses = 0;
      mm_at_done  = 0;
      mm_other    = 0;
      frame_done  = 1'b0;
      for (int c = 0; c < 4000 && !frame_done; c++) begin
         tx_log.push_back(tx_o);
         if (busy_o) busy_clocks++;
         if (done_o) begin
            done_pulses++;
            frame_done = 1'b1;
            if (mismatch_o) mm_at_done++;
         end else if (mismatch_o) begin
            mm_other++;
         end
         start_i   = (c == mid_start_at);
         rx_int_i  = (c == rx_at);
         err_int_i = (c == err_at);
         @(negedge clk);
      end
      start_i   = 1'b0;
      rx_int_i  = 1'b0;
      err_int_i = 1'b0;
      checks++;
      if (!frame_done) begin
         errors++;
         $display("[TB] FAIL frame_timeout: done_o not seen, got busy clocks %0d", busy_clocks);
      end
      for (int c = 0; c < 2; c++) begin
         if (done_o) done_pulses++;
         if (mismatch_o) mm_other++;
         @(negedge clk);
      end
   endtask

   // Line level at the first clock of each bit, bit k in position k
   function automatic logic [31:0] decode_bits(input int bt, input int n);
      logic [31:0] v;
      v = '0;
      for (int b = 0; b < n; b++) begin
         if (b * (bt + 1) < tx_log.size()) v[b] = tx_log[b * (bt + 1)];
         else v[b] = 1'bx;
      end
      return v;
   endfunction

   // Whether the line held steady across every clock of each bit period
   function automatic logic bits_stable(input int bt, input int n);
      for (int b = 0; b < n; b++) begin
         for (int k = 0; k < bt + 1; k++) begin
            if (b * (bt + 1) + k >= tx_log.size()) return 1'b0;
            if (tx_log[b * (bt + 1) + k] !== tx_log[b * (bt + 1)]) return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   // Reset values with the reset held, then idle after release
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", tx_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done_o); end
      checks++; if (mismatch_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mismatch: got %b want 0", mismatch_o); end
      checks++; if ({rx_cnt_o, err_cnt_o, sent_cnt_o, mismatch_cnt_o} !== 16'h0000) begin
         errors++; $display("[TB] FAIL reset_counters: got %h want 0000", {rx_cnt_o, err_cnt_o, sent_cnt_o, mismatch_cnt_o});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({busy_o, tx_o} !== 2'b01) begin errors++; $display("[TB] FAIL idle_after_reset: got busy/tx %b want 01", {busy_o, tx_o}); end
   endtask

   // Mode 00: 0xA5, 4 clocks per bit, no gap
   task automatic test_mode_none();
      logic [31:0] bits;
      run_frame(2'b00, 8'hA5, 1'b0, 16'd3, 4'd0, -1, -1, -1);
      bits = decode_bits(3, 10);
      checks++; if (bits !== 32'b11_0100_1010) begin errors++; $display("[TB] FAIL none_bits: got %b want %b", bits, 32'b11_0100_1010); end
      checks++; if (bits_stable(3, 10) !== 1'b1) begin errors++; $display("[TB] FAIL none_bit_len: got unstable bit periods want 4 clocks each"); end
      checks++; if (busy_clocks != 40) begin errors++; $display("[TB] FAIL none_busy: got %0d want 40", busy_clocks); end
      checks++; if (done_pulses != 1) begin errors++; $display("[TB] FAIL none_done: got %0d pulses want 1", done_pulses); end
      checks++; if (tx_log.size() != 41 || tx_log[40] !== 1'b1) begin
         errors++; $display("[TB] FAIL none_done_cycle: got log size %0d want 41 with idle line", tx_log.size());
      end
      checks++; if (sent_cnt_o !== 4'd1) begin errors++; $display("[TB] FAIL none_sent: got %0d want 1", sent_cnt_o); end
   endtask

   // Mode 01: 0x07 has odd weight, parity bit 1; with inject it flips to 0
   task automatic test_parity();
      logic [31:0] bits;
      run_frame(2'b01, 8'h07, 1'b0, 16'd3, 4'd0, -1, -1, -1);
      bits = decode_bits(3, 11);
      checks++; if (bits !== 32'b110_0000_1110) begin errors++; $display("[TB] FAIL par_bits: got %b want %b", bits, 32'b110_0000_1110); end
      checks++; if (busy_clocks != 44) begin errors++; $display("[TB] FAIL par_busy: got %0d want 44", busy_clocks); end
      run_frame(2'b01, 8'h07, 1'b1, 16'd3, 4'd0, -1, -1, -1);
      bits = decode_bits(3, 11);
      checks++; if (bits !== 32'b100_0000_1110) begin errors++; $display("[TB] FAIL par_inj_bits: got %b want %b", bits, 32'b100_0000_1110); end
      checks++; if (busy_clocks != 44) begin errors++; $display("[TB] FAIL par_inj_busy: got %0d want 44", busy_clocks); end
      checks++; if (sent_cnt_o !== 4'd3) begin errors++; $display("[TB] FAIL par_sent: got %0d want 3", sent_cnt_o); end
   endtask

   // Mode 10: 0x55 gives CRC 0xAC; two gap bits; a start mid-frame is ignored
   task automatic test_crc();
      logic [31:0] bits;
      run_frame(2'b10, 8'h55, 1'b0, 16'd3, 4'd2, 30, -1, -1);
      bits = decode_bits(3, 20);
      checks++; if (bits !== 32'b1111_0101_1000_1010_1010) begin
         errors++; $display("[TB] FAIL crc_bits: got %b want %b", bits, 32'b1111_0101_1000_1010_1010);
      end
      checks++; if (bits_stable(3, 20) !== 1'b1) begin errors++; $display("[TB] FAIL crc_bit_len: got unstable bit periods want 4 clocks each"); end
      checks++; if (busy_clocks != 80) begin errors++; $display("[TB] FAIL crc_busy: got %0d want 80", busy_clocks); end
      checks++; if (done_pulses != 1) begin errors++; $display("[TB] FAIL crc_done: got %0d pulses want 1", done_pulses); end
      checks++; if (sent_cnt_o !== 4'd4) begin errors++; $display("[TB] FAIL crc_sent: got %0d want 4", sent_cnt_o); end
   endtask

   // Edge counting, clear priority and saturation of the 4-bit counters
   task automatic test_counters();
      cnt_clr_i = 1'b1;
      @(negedge clk);
      cnt_clr_i = 1'b0;
      checks++; if ({rx_cnt_o, err_cnt_o, sent_cnt_o} !== 12'h000) begin
         errors++; $display("[TB] FAIL clr_all: got %h want 000", {rx_cnt_o, err_cnt_o, sent_cnt_o});
      end
      err_int_i = 1'b1;
      repeat (5) @(negedge clk);
      err_int_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (err_cnt_o !== 4'd1) begin errors++; $display("[TB] FAIL err_level: got %0d want 1", err_cnt_o); end
      for (int p = 0; p < 3; p++) begin
         rx_int_i = 1'b1;
         @(negedge clk);
         rx_int_i = 1'b0;
         @(negedge clk);
      end
      checks++; if (rx_cnt_o !== 4'd3) begin errors++; $display("[TB] FAIL rx_pulses: got %0d want 3", rx_cnt_o); end
      rx_int_i  = 1'b1;
      cnt_clr_i = 1'b1;
      @(negedge clk);
      cnt_clr_i = 1'b0;
      checks++; if (rx_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL clr_vs_edge: got %0d want 0", rx_cnt_o); end
      repeat (2) @(negedge clk);
      rx_int_i = 1'b0;
      @(negedge clk);
      checks++; if (rx_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL rx_held: got %0d want 0", rx_cnt_o); end
      for (int p = 0; p < 17; p++) begin
         rx_int_i = 1'b1;
         @(negedge clk);
         rx_int_i = 1'b0;
         @(negedge clk);
      end
      checks++; if (rx_cnt_o !== 4'd15) begin errors++; $display("[TB] FAIL rx_saturate: got %0d want 15", rx_cnt_o); end
      checks++; if (err_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL err_after_clr: got %0d want 0", err_cnt_o); end
   endtask

   // Reset inside DATA aborts the frame; the next frame is clean
   task automatic test_reset_midframe();
      logic [31:0] bits;
      int          seen_done;
      @(negedge clk);
      mode_i = 2'b00; data_i = 8'hA5; inject_err_i = 1'b0; bit_time_i = 16'd3; idle_bits_i = 4'd0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      checks++; if ({busy_o, tx_o} !== 2'b10) begin errors++; $display("[TB] FAIL mid_before: got busy/tx %b want 10", {busy_o, tx_o}); end
      rst_n = 1'b0;
      #1;
      checks++; if ({tx_o, busy_o, done_o} !== 3'b100) begin
         errors++; $display("[TB] FAIL mid_reset_outputs: got tx/busy/done %b want 100", {tx_o, busy_o, done_o});
      end
      checks++; if (rx_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_cnt: got %0d want 0", rx_cnt_o); end
      seen_done = 0;
      repeat (2) begin
         @(negedge clk);
         if (done_o) seen_done++;
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (done_o || busy_o) seen_done++;
      end
      checks++; if (seen_done != 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d done/busy cycles want 0", seen_done); end
      run_frame(2'b00, 8'hA5, 1'b0, 16'd3, 4'd0, -1, -1, -1);
      bits = decode_bits(3, 10);
      checks++; if (bits !== 32'b11_0100_1010) begin errors++; $display("[TB] FAIL mid_next_bits: got %b want %b", bits, 32'b11_0100_1010); end
      checks++; if (busy_clocks != 40) begin errors++; $display("[TB] FAIL mid_next_busy: got %0d want 40", busy_clocks); end
      checks++; if (sent_cnt_o !== 4'd1) begin errors++; $display("[TB] FAIL mid_next_sent: got %0d want 1", sent_cnt_o); end
   endtask

   // Per-frame interrupt outcome checking (inert when the feature is not built)
   task automatic test_autochk();
      cnt_clr_i = 1'b1;
      @(negedge clk);
      cnt_clr_i = 1'b0;
      checks++; if (mismatch_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL ac_clr: got %0d want 0", mismatch_cnt_o); end
      run_frame(2'b01, 8'h07, 1'b1, 16'd1, 4'd0, -1, 10, -1);
      checks++; if (mm_at_done != (AUTOCHK ? 1 : 0)) begin errors++; $display("[TB] FAIL ac_wrong_irq: got %0d want %0d", mm_at_done, AUTOCHK ? 1 : 0); end
      checks++; if (mismatch_cnt_o !== (AUTOCHK ? 4'd1 : 4'd0)) begin
         errors++; $display("[TB] FAIL ac_cnt1: got %0d want %0d", mismatch_cnt_o, AUTOCHK ? 1 : 0);
      end
      checks++; if (rx_cnt_o !== 4'd1) begin errors++; $display("[TB] FAIL ac_rx_cnt: got %0d want 1", rx_cnt_o); end
      run_frame(2'b01, 8'h07, 1'b1, 16'd1, 4'd0, -1, -1, 10);
      checks++; if (mm_at_done != 0) begin errors++; $display("[TB] FAIL ac_err_ok: got %0d want 0", mm_at_done); end
      run_frame(2'b00, 8'h07, 1'b1, 16'd1, 4'd0, -1, 12, -1);
      checks++; if (mm_at_done != 0) begin errors++; $display("[TB] FAIL ac_mode0_inj: got %0d want 0", mm_at_done); end
      run_frame(2'b10, 8'h55, 1'b0, 16'd0, 4'd1, -1, -1, -1);
      checks++; if (mm_at_done != (AUTOCHK ? 1 : 0)) begin errors++; $display("[TB] FAIL ac_no_irq: got %0d want %0d", mm_at_done, AUTOCHK ? 1 : 0); end
      checks++; if (mismatch_cnt_o !== (AUTOCHK ? 4'd2 : 4'd0)) begin
         errors++; $display("[TB] FAIL ac_cnt2: got %0d want %0d", mismatch_cnt_o, AUTOCHK ? 2 : 0);
      end
      checks++; if (mm_other != 0) begin errors++; $display("[TB] FAIL ac_stray: got %0d stray pulses want 0", mm_other); end
   endtask

   // Test sequence
   initial begin
      rst_n        = 1'b0;
      start_i      = 1'b0;
      mode_i       = 2'b00;
      inject_err_i = 1'b0;
      data_i       = 8'h00;
      bit_time_i   = 16'd0;
      idle_bits_i  = 4'd0;
      rx_int_i     = 1'b0;
      err_int_i    = 1'b0;
      cnt_clr_i    = 1'b0;
      test_reset();
      test_mode_none();
      test_parity();
      test_crc();
      test_counters();
      test_reset_midframe();
      test_autochk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the bench always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no completion want $finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
